// File: rtl/mem_lsu_pkg.sv
// lsu_pkg: shared FSM states, RV32I size codes, op record and alignment check for mem_lsu.
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic        we;
    logic [31:0] wdata;
  } lsu_op_t;
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return f3[1:0] == F3_B[1:0] ? 1'b0 : f3[1:0] == F3_H[1:0] ? off[0] : |off;
  endfunction
endpackage

// File: rtl/mem_lsu_align.sv
// lsu_align: byte enables, lane-replicated store data and extended load data for one access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] wd,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);
  logic        is_b, is_h, sx;
  logic [1:0]  aoff;
  logic [31:0] sh;
  // Codes other than B/H/BU/HU all have funct3[1:0] >= 2 and fall through to word.
  assign is_b  = funct3[1:0] == F3_B[1:0];
  assign is_h  = funct3[1:0] == F3_H[1:0];
  assign sx    = ~funct3[2];
  assign aoff  = is_b ? off : is_h ? {off[1], 1'b0} : 2'b00;
  assign be    = is_b ? 4'b0001 << aoff : is_h ? 4'b0011 << aoff : 4'b1111;
  assign wdata = is_b ? {4{wd[7:0]}} : is_h ? {2{wd[15:0]}} : wd;
  assign sh    = rdata >> {aoff, 3'b000};
  assign ldata = is_b ? {{24{sx & sh[7]}}, sh[7:0]} :
                 is_h ? {{16{sx & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit running a valid/ready data-memory transaction with timeout.
// Define MEM_LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing alignment.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic        DoneM,
  output logic [31:0] LoadDataM,
  output logic        BusErrM,
  output logic        MisalignM,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata
);
  localparam int CW = $clog2(TIMEOUT);
  lsu_state_t  state_q, state_d;
  lsu_op_t     op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d, ld, al_wdata;
  logic        err_q, err_d, mis_q, mis_d, req;
  logic [3:0]  al_be;
  lsu_align u_align (
    .funct3(op_q.funct3),
    .off   (op_q.addr[1:0]),
    .rdata (dmem_rdata),
    .wd    (op_q.wdata),
    .be    (al_be),
    .wdata (al_wdata),
    .ldata (ld)
  );
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: if (MemReqM) begin
        op_d    = '{addr: AddrM, funct3: Funct3M, we: MemWriteM, wdata: WriteDataM};
        data_d  = '0;
        err_d   = 1'b0;
        mis_d   = 1'b0;
        state_d = REQ;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        if (misaligned(Funct3M, AddrM[1:0])) begin
          mis_d   = 1'b1;
          state_d = DONE;
        end
`endif
      end
      REQ: if (dmem_req_ready) begin
        cnt_d   = '0;
        state_d = RESP;
      end
      RESP: if (dmem_rsp_valid) begin
        data_d  = op_q.we ? 32'h0 : ld;
        state_d = DONE;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end
  assign req            = state_q == REQ;
  assign StallM         = (state_q == IDLE && MemReqM) || req || state_q == RESP;
  assign DoneM          = state_q == DONE;
  assign LoadDataM      = DoneM ? data_q : 32'h0;
  assign BusErrM        = DoneM & err_q;
  assign MisalignM      = DoneM & mis_q;
  assign dmem_req_valid = req;
  assign dmem_we        = req & op_q.we;
  assign dmem_addr      = req ? {op_q.addr[31:2], 2'b00} : 32'h0;
  assign dmem_be        = req ? al_be : 4'h0;
  assign dmem_wdata     = req ? al_wdata : 32'h0;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: table-driven directed checks of mem_lsu plus stall, timeout, reset and misalign sequences.
module tb_mem_lsu;
  logic        clk = 1'b0, reset = 1'b1;
  logic        MemReqM = 1'b0, MemWriteM = 1'b0;
  logic [2:0]  Funct3M = 3'b0;
  logic [31:0] AddrM = 32'h0, WriteDataM = 32'h0;
  logic        StallM, DoneM, BusErrM, MisalignM;
  logic [31:0] LoadDataM;
  logic        dmem_req_valid, dmem_we;
  logic        dmem_req_ready = 1'b0, dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = 32'h0;
  logic [3:0]  dmem_be;
  int n_cmp = 0, n_bad = 0;

  mem_lsu #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .AddrM(AddrM), .WriteDataM(WriteDataM),
    .StallM(StallM), .DoneM(DoneM), .LoadDataM(LoadDataM), .BusErrM(BusErrM),
    .MisalignM(MisalignM), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        we;
    logic [31:0] addr, wd, rdata, e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_ld;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic we, input logic [31:0] a, input logic [31:0] wd);
    MemReqM = 1'b1; Funct3M = f3; MemWriteM = we; AddrM = a; WriteDataM = wd;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    drive(v.f3, v.we, v.addr, v.wd);
    #1;
    chk($sformatf("v%0d stall_idle", i), 32'(StallM), 32'd1);
    tick();
    Funct3M = 3'b000; AddrM = 32'hFFFF_FFFF; WriteDataM = ~v.wd; MemWriteM = ~v.we;
    #1;
    chk($sformatf("v%0d req_valid", i), 32'(dmem_req_valid), 32'd1);
    chk($sformatf("v%0d addr", i), dmem_addr, v.e_addr);
    chk($sformatf("v%0d be", i), 32'(dmem_be), 32'(v.e_be));
    chk($sformatf("v%0d we", i), 32'(dmem_we), 32'(v.we));
    chk($sformatf("v%0d wdata", i), dmem_wdata, v.e_wd);
    chk($sformatf("v%0d stall_req", i), 32'(StallM), 32'd1);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    chk($sformatf("v%0d stall_resp", i), 32'(StallM), 32'd1);
    chk($sformatf("v%0d valid_resp", i), 32'(dmem_req_valid), 32'd0);
    dmem_rsp_valid = 1'b1; dmem_rdata = v.rdata;
    tick();
    dmem_rsp_valid = 1'b0; dmem_rdata = 32'h0;
    chk($sformatf("v%0d done", i), 32'(DoneM), 32'd1);
    chk($sformatf("v%0d load", i), LoadDataM, v.e_ld);
    chk($sformatf("v%0d buserr", i), 32'(BusErrM), 32'd0);
    chk($sformatf("v%0d misalign", i), 32'(MisalignM), 32'd0);
    chk($sformatf("v%0d stall_done", i), 32'(StallM), 32'd0);
    tick();
    chk($sformatf("v%0d done_once", i), 32'(DoneM), 32'd0);
    chk($sformatf("v%0d no_resample", i), 32'(dmem_req_valid), 32'd0);
    MemReqM = 1'b0;
    #1;
    chk($sformatf("v%0d stall_after", i), 32'(StallM), 32'd0);
  endtask

  initial begin
    int nvec, k;
    vt[0]  = '{3'b010, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF};
    vt[1]  = '{3'b000, 1'b0, 32'h203, 32'h0, 32'h80FFFF12, 32'h200, 4'b1000, 32'h0, 32'hFFFFFF80};
    vt[2]  = '{3'b100, 1'b0, 32'h203, 32'h0, 32'h80FFFF12, 32'h200, 4'b1000, 32'h0, 32'h00000080};
    vt[3]  = '{3'b001, 1'b1, 32'h302, 32'h1234ABCD, 32'h55555555, 32'h300, 4'b1100, 32'hABCDABCD, 32'h0};
    vt[4]  = '{3'b001, 1'b0, 32'h102, 32'h0, 32'h80017FFF, 32'h100, 4'b1100, 32'h0, 32'hFFFF8001};
    vt[5]  = '{3'b101, 1'b0, 32'h100, 32'h0, 32'h80019ABC, 32'h100, 4'b0011, 32'h0, 32'h00009ABC};
    vt[6]  = '{3'b000, 1'b1, 32'h401, 32'h000000A5, 32'h0, 32'h400, 4'b0010, 32'hA5A5A5A5, 32'h0};
    vt[7]  = '{3'b010, 1'b1, 32'h500, 32'hCAFEF00D, 32'h0, 32'h500, 4'b1111, 32'hCAFEF00D, 32'h0};
    vt[8]  = '{3'b000, 1'b0, 32'h000, 32'h0, 32'h0000007F, 32'h000, 4'b0001, 32'h0, 32'h0000007F};
    vt[9]  = '{3'b011, 1'b0, 32'h600, 32'h0, 32'h12345678, 32'h600, 4'b1111, 32'h0, 32'h12345678};
    vt[10] = '{3'b010, 1'b0, 32'h101, 32'h0, 32'h11223344, 32'h100, 4'b1111, 32'h0, 32'h11223344};
    vt[11] = '{3'b001, 1'b0, 32'h103, 32'h0, 32'hF0001234, 32'h100, 4'b1100, 32'h0, 32'hFFFFF000};
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    nvec = 10;
`else
    nvec = 12;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst StallM", 32'(StallM), 32'd0);
    chk("rst DoneM", 32'(DoneM), 32'd0);
    chk("rst LoadDataM", LoadDataM, 32'h0);
    chk("rst BusErrM", 32'(BusErrM), 32'd0);
    chk("rst MisalignM", 32'(MisalignM), 32'd0);
    chk("rst req_valid", 32'(dmem_req_valid), 32'd0);
    chk("rst we_be", {27'h0, dmem_we, dmem_be}, 32'h0);
    chk("rst addr", dmem_addr, 32'h0);
    chk("rst wdata", dmem_wdata, 32'h0);
    for (int i = 0; i < nvec; i++) run_vec(vt[i], i);

    // ready held low: request must stay frozen and the pipeline stalled
    drive(3'b000, 1'b1, 32'h702, 32'h0000003C);
    tick();
    MemReqM = 1'b1; AddrM = 32'h0; WriteDataM = 32'h0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("hold%0d valid", c), 32'(dmem_req_valid), 32'd1);
      chk($sformatf("hold%0d addr", c), dmem_addr, 32'h700);
      chk($sformatf("hold%0d be", c), 32'(dmem_be), 32'b0100);
      chk($sformatf("hold%0d wdata", c), dmem_wdata, 32'h3C3C3C3C);
      chk($sformatf("hold%0d stall", c), 32'(StallM), 32'd1);
      tick();
    end
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    chk("hold stall_resp", 32'(StallM), 32'd1);
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'h0BADF00D;
    tick();
    dmem_rsp_valid = 1'b0;
    chk("hold done", 32'(DoneM), 32'd1);
    chk("hold store_load0", LoadDataM, 32'h0);
    MemReqM = 1'b0;
    tick();

    // no response: bus error exactly TIMEOUT cycles after entering RESP
    drive(3'b010, 1'b0, 32'h800, 32'h0);
    tick();
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    k = -1;
    for (int c = 0; c < 40; c++) begin
      if (DoneM) begin
        k = c;
        break;
      end
      if (!StallM) begin
        chk("tmo stall", 32'(StallM), 32'd1);
        break;
      end
      tick();
    end
    chk("tmo cycles", 32'(k), 32'd16);
    chk("tmo buserr", 32'(BusErrM), 32'd1);
    chk("tmo load", LoadDataM, 32'h0);
    MemReqM = 1'b0;
    tick();
    chk("tmo done_once", 32'(DoneM), 32'd0);

    // reset mid-transaction, then a stray response in IDLE is dropped
    drive(3'b010, 1'b0, 32'hA00, 32'h0);
    tick();
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    MemReqM = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rmid stall", 32'(StallM), 32'd0);
    chk("rmid valid", 32'(dmem_req_valid), 32'd0);
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    tick();
    dmem_rsp_valid = 1'b0;
    chk("rmid done1", 32'(DoneM), 32'd0);
    tick();
    chk("rmid done2", 32'(DoneM), 32'd0);
    chk("rmid load", LoadDataM, 32'h0);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    drive(3'b010, 1'b0, 32'h101, 32'h0);
    #1;
    chk("trapw stall", 32'(StallM), 32'd1);
    tick();
    chk("trapw valid", 32'(dmem_req_valid), 32'd0);
    chk("trapw done", 32'(DoneM), 32'd1);
    chk("trapw misalign", 32'(MisalignM), 32'd1);
    chk("trapw load", LoadDataM, 32'h0);
    MemReqM = 1'b0;
    tick();
    chk("trapw done_once", 32'(DoneM), 32'd0);
    drive(3'b001, 1'b1, 32'h303, 32'hFFFF);
    tick();
    chk("traph valid", 32'(dmem_req_valid), 32'd0);
    chk("traph we", 32'(dmem_we), 32'd0);
    chk("traph misalign", 32'(MisalignM), 32'd1);
    MemReqM = 1'b0;
    tick();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
